pipe_elastic: RTL and testbench

PIPE_ELASTIC -- requirements
Module: pipe_elastic

---
 rtl/pipe_elastic.sv | 93 +++++++++
 tb/tb_pipe_elastic.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic.sv
// rtl/pipe_elastic.sv - elastic valid/ready pipeline with bubble collapse and an input skid entry
module pipe_elastic #(
  parameter int DATA_W = 32,
  parameter int STAGES = 1,
  parameter int OCC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  logic [STAGES-1:0] v_q, v_d, ld;
  logic [DATA_W-1:0] d_q [STAGES];
  logic [DATA_W-1:0] d_d [STAGES];
  logic              k_v_q, k_v_d;
  logic [DATA_W-1:0] k_d_q, k_d_d;
  logic              rdy_q;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              in_fire, out_fire, go;

  always_comb begin
    in_fire  = in_valid & rdy_q;
    out_fire = v_q[STAGES-1] & out_ready;

    // A slot may load when empty or when its own beat moves on this cycle.
    go = out_ready;
    ld = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ld[i] = ~v_q[i] | go;
      go    = ld[i];
    end

    v_d   = v_q;
    k_v_d = k_v_q;
    k_d_d = k_d_q;
    for (int i = 0; i < STAGES; i++) d_d[i] = d_q[i];

    if (ld[0]) begin
      v_d[0] = k_v_q | in_fire;
      d_d[0] = k_v_q ? k_d_q : in_data;
      k_v_d  = 1'b0;
    end else if (in_fire) begin
      k_v_d = 1'b1;
      k_d_d = in_data;
    end

    for (int i = 1; i < STAGES; i++) begin
      if (ld[i]) begin
        v_d[i] = v_q[i-1];
        d_d[i] = d_q[i-1];
      end
    end

    occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);

    if (flush) begin
      v_d   = '0;
      k_v_d = 1'b0;
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q   <= '0;
      k_v_q <= 1'b0;
      k_d_q <= '0;
      rdy_q <= 1'b0;
      occ_q <= '0;
      for (int i = 0; i < STAGES; i++) d_q[i] <= '0;
    end else begin
      v_q   <= v_d;
      k_v_q <= k_v_d;
      k_d_q <= k_d_d;
      rdy_q <= ~k_v_d;
      occ_q <= occ_d;
      for (int i = 0; i < STAGES; i++) d_q[i] <= d_d[i];
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_elastic.sv
// tb/tb_pipe_elastic.sv - bench for pipe_elastic at STAGES 1..4 sharing one stimulus bus
module tb_pipe_elastic;

  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        rdy1, rdy2, rdy3, rdy4, ov1, ov2, ov3, ov4;
  logic [7:0]  od1;
  logic [31:0] od2, od3, od4;
  logic [3:0]  occ1, occ2, occ3, occ4;
  int          tests, fails;

  pipe_elastic #(.DATA_W(8), .STAGES(1), .OCC_W(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data[7:0]), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1));
  pipe_elastic #(.DATA_W(32), .STAGES(2), .OCC_W(4)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .occupancy(occ2));
  pipe_elastic #(.DATA_W(32), .STAGES(3), .OCC_W(4)) u3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy3),
    .in_data(in_data), .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .occupancy(occ3));
  pipe_elastic #(.DATA_W(32), .STAGES(4), .OCC_W(4)) u4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .occupancy(occ4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2 rst = 1'b0;
    #1;
    tests++;
    if (ov3 !== 1'b0 || od3 !== 32'h0 || occ3 !== 4'd0 || rdy3 !== 1'b0) begin
      fails++;
      $display("FAIL reset_async ov=%0b od=%0h occ=%0d rdy=%0b expected 0 0 0 0", ov3, od3, occ3, rdy3);
    end
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (rdy3 !== 1'b0 || ov3 !== 1'b0 || occ3 !== 4'd0) begin
      fails++;
      $display("FAIL reset_held rdy=%0b ov=%0b occ=%0d expected 0 0 0", rdy3, ov3, occ3);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (rdy3 !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_edge_ready got %0b expected 1", rdy3);
    end
    tests++;
    if (occ3 !== 4'd0 || ov3 !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_empty occ=%0d ov=%0b expected 0 0", occ3, ov3);
    end
  endtask

  task automatic test_latency();
    logic        exp_v;
    logic [31:0] exp_d;
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      in_valid = (k <= 3);
      in_data  = 32'(32'h11 * k);
      @(negedge clk);
      exp_v = (k >= 3 && k <= 5);
      exp_d = 32'(32'h11 * (k - 2));
      tests++;
      if (ov3 !== exp_v) begin
        fails++;
        $display("FAIL latency_valid edge %0d got %0b expected %0b", k, ov3, exp_v);
      end
      if (exp_v) begin
        tests++;
        if (od3 !== exp_d) begin
          fails++;
          $display("FAIL latency_data edge %0d got %0h expected %0h", k, od3, exp_d);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int          acc;
    logic        fire;
    logic [31:0] got[$];
    do_reset();
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(acc);
      fire     = rdy2;
      @(negedge clk);
      if (fire) acc++;
    end
    tests++;
    if (acc != 3 || rdy2 !== 1'b0 || occ2 !== 4'd3) begin
      fails++;
      $display("FAIL backpressure_fill acc=%0d rdy=%0b occ=%0d expected 3 0 3", acc, rdy2, occ2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (ov2) got.push_back(od2);
      @(negedge clk);
    end
    tests++;
    if (got.size() != 3) begin
      fails++;
      $display("FAIL backpressure_count got %0d expected 3", got.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        tests++;
        if (got[j] !== 32'hA0 + 32'(j)) begin
          fails++;
          $display("FAIL backpressure_order beat %0d got %0h expected %0h", j, got[j], 32'hA0 + 32'(j));
        end
      end
    end
    tests++;
    if (rdy2 !== 1'b1 || occ2 !== 4'd0) begin
      fails++;
      $display("FAIL backpressure_drain rdy=%0b occ=%0d expected 1 0", rdy2, occ2);
    end
  endtask

  task automatic test_random();
    int          sent, occm, cyc;
    logic [31:0] q[$];
    logic [31:0] exp;
    do_reset();
    sent = 0; occm = 0; cyc = 0;
    while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
      tests++;
      if (occ4 !== occm) begin
        fails++;
        $display("FAIL random_occ cycle %0d got %0d expected %0d", cyc, occ4, occm);
      end
      tests++;
      if (rdy4 !== (occm != 5)) begin
        fails++;
        $display("FAIL random_ready cycle %0d got %0b expected %0b", cyc, rdy4, (occm != 5));
      end
      in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      out_ready = (sent >= 10000) || ($urandom_range(0, 9) < 6);
      if (ov4 && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL random_spurious cycle %0d got %0h expected no beat", cyc, od4);
        end else begin
          exp = q.pop_front();
          if (od4 !== exp) begin
            fails++;
            $display("FAIL random_data cycle %0d got %0h expected %0h", cyc, od4, exp);
          end
        end
        occm--;
      end
      if (in_valid && rdy4) begin
        q.push_back(in_data);
        sent++;
        occm++;
      end
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc >= 60000) begin
      fails++;
      $display("FAIL random_timeout sent=%0d pending=%0d expected all drained", sent, q.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_data  = 32'hB0 + 32'(j);
      @(negedge clk);
    end
    tests++;
    if (occ2 !== 4'd3 || rdy2 !== 1'b0) begin
      fails++;
      $display("FAIL flush_prefill occ=%0d rdy=%0b expected 3 0", occ2, rdy2);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;
    tests++;
    if (ov2 !== 1'b1 || od2 !== 32'hB0) begin
      fails++;
      $display("FAIL flush_out_transfer ov=%0b od=%0h expected 1 b0", ov2, od2);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    tests++;
    if (ov2 !== 1'b0 || occ2 !== 4'd0 || rdy2 !== 1'b1) begin
      fails++;
      $display("FAIL flush_after ov=%0b occ=%0d rdy=%0b expected 0 0 1", ov2, occ2, rdy2);
    end
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (ov2 !== 1'b0) begin
        fails++;
        $display("FAIL flush_leak cycle %0d got ov=%0b od=%0h expected 0", c, ov2, od2);
      end
      @(negedge clk);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hBEEF; out_ready = 1'b0;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    tests++;
    if (ov1 !== 1'b0 || occ1 !== 4'd0 || rdy1 !== 1'b1) begin
      fails++;
      $display("FAIL flush_drop_input ov=%0b occ=%0d rdy=%0b expected 0 0 1", ov1, occ1, rdy1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1;
      in_data  = 32'hC0 + 32'(j);
      @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if (ov3 !== 1'b0 || od3 !== 32'h0 || occ3 !== 4'd0 || rdy3 !== 1'b0) begin
      fails++;
      $display("FAIL midstream_reset ov=%0b od=%0h occ=%0d rdy=%0b expected 0 0 0 0", ov3, od3, occ3, rdy3);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (rdy3 !== 1'b1) begin
      fails++;
      $display("FAIL midstream_release_ready got %0b expected 1", rdy3);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (ov3 !== 1'b0 || occ3 !== 4'd0) begin
        fails++;
        $display("FAIL midstream_stale cycle %0d ov=%0b occ=%0d expected 0 0", c, ov3, occ3);
      end
    end
  endtask

  task automatic test_stable();
    logic [7:0] q1[$];
    logic [7:0] prev_d, exp;
    logic       prev_hold;
    do_reset();
    prev_hold = 1'b0;
    prev_d    = '0;
    for (int c = 0; c < 60; c++) begin
      if (prev_hold) begin
        tests++;
        if (ov1 !== 1'b1 || od1 !== prev_d) begin
          fails++;
          $display("FAIL stable_hold cycle %0d ov=%0b od=%0h expected 1 %0h", c, ov1, od1, prev_d);
        end
      end
      in_valid  = 1'b1;
      in_data   = 32'(c + 1);
      out_ready = (c % 2) == 1;
      if (ov1 && out_ready) begin
        tests++;
        if (q1.size() == 0) begin
          fails++;
          $display("FAIL stable_spurious cycle %0d got %0h expected no beat", c, od1);
        end else begin
          exp = q1.pop_front();
          if (od1 !== exp) begin
            fails++;
            $display("FAIL stable_order cycle %0d got %0h expected %0h", c, od1, exp);
          end
        end
      end
      if (in_valid && rdy1) q1.push_back(in_data[7:0]);
      prev_hold = ov1 && !out_ready;
      prev_d    = od1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_latency();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_stable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
